// File: rtl/ow_slave_array.sv
// NUM_SLAVES emulated 1-Wire slaves on one open-drain bus: reset/presence, Read/Match/Skip ROM
// and Search ROM with wired-AND arbitration across all still-selected slaves.
module ow_slave_array #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned RST_MIN_CYC = 480,
  parameter int unsigned PD_WAIT_CYC = 30,
  parameter int unsigned PD_LEN_CYC  = 120,
  parameter int unsigned SAMPLE_CYC  = 15,
  parameter int unsigned DRIVE_CYC   = 30
) (
  input  logic                     CLK,
  input  logic                     MR,
  input  logic                     IO_IN,
  output logic                     IO_PD,
  input  logic [64*NUM_SLAVES-1:0] ROMIDS,
  input  logic [NUM_SLAVES-1:0]    SLAVE_EN,
  output logic [NUM_SLAVES-1:0]    ACTIVE,
  output logic [7:0]               CMD,
  output logic                     CMD_VALID,
  output logic                     BUSY
);

  typedef enum logic [3:0] {
    StIdle, StRstLow, StPdWait, StPdDrive, StCmdRx, StRomTx, StMatch, StSearch, StDone
  } state_e;

  typedef enum logic [1:0] {SubBit, SubCmp, SubDir} sub_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e            state;
  sub_e              sub;
  logic              io_prev;
  logic [CNT_W-1:0]  low_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  drv_cnt;
  logic [5:0]        idx;
  logic [6:0]        cmd_sr;
  logic              wr_slot;

  logic                  fall;
  logic                  rise;
  logic                  bus_rst;
  logic                  sample;
  logic                  slot_st;
  logic                  wr_st;
  logic                  any0;
  logic                  any1;
  logic [7:0]            cmd_byte;
  logic [NUM_SLAVES-1:0] cur_bit;
  logic [NUM_SLAVES-1:0] keep;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bit
    logic [63:0] id;
    assign id         = ROMIDS[64*g +: 64];
    assign cur_bit[g] = id[idx];
  end

  assign fall     = !IO_IN && io_prev;
  assign rise     = IO_IN && !io_prev;
  assign bus_rst  = !IO_IN && (low_cnt == CNT_W'(RST_MIN_CYC - 1));
  // Only write slots that actually started in a receiving state may be sampled.
  assign sample   = wr_slot && (cnt == CNT_W'(SAMPLE_CYC));
  assign slot_st  = state inside {StCmdRx, StRomTx, StMatch, StSearch};
  assign wr_st    = (state == StCmdRx) || (state == StMatch) ||
                    ((state == StSearch) && (sub == SubDir));
  assign any0     = |(ACTIVE & ~cur_bit);
  assign any1     = |(ACTIVE & cur_bit);
  assign keep     = ~(cur_bit ^ {NUM_SLAVES{IO_IN}});
  assign cmd_byte = {IO_IN, cmd_sr};
  assign BUSY     = (state != StIdle);

  always_ff @(posedge CLK) begin
    if (MR) begin
      state     <= StIdle;
      sub       <= SubBit;
      io_prev   <= 1'b1;
      low_cnt   <= '0;
      cnt       <= '0;
      drv_cnt   <= '0;
      idx       <= '0;
      cmd_sr    <= '0;
      wr_slot   <= 1'b0;
      IO_PD     <= 1'b0;
      ACTIVE    <= '0;
      CMD       <= '0;
      CMD_VALID <= 1'b0;
    end else begin
      io_prev   <= IO_IN;
      CMD_VALID <= 1'b0;
      low_cnt   <= IO_IN ? '0 : ((low_cnt == CntMax) ? CntMax : low_cnt + CntOne);
      if (cnt != CntMax) cnt <= cnt + CntOne;
      // Slot drive runs on its own timer so it outlives the state that started it.
      if (drv_cnt != '0) begin
        if (drv_cnt == CNT_W'(DRIVE_CYC)) begin
          IO_PD   <= 1'b0;
          drv_cnt <= '0;
        end else begin
          drv_cnt <= drv_cnt + CntOne;
        end
      end

      if (bus_rst) begin
        state   <= StRstLow;
        sub     <= SubBit;
        IO_PD   <= 1'b0;
        drv_cnt <= '0;
        cnt     <= '0;
        idx     <= '0;
        wr_slot <= 1'b0;
      end else begin
        if (fall && slot_st) begin
          cnt     <= CntOne;
          wr_slot <= wr_st;
        end

        case (state)
          StIdle: ;
          StRstLow: begin
            if (rise) begin
              state <= StPdWait;
              cnt   <= CntOne;
            end
          end
          StPdWait: begin
            if (cnt == CNT_W'(PD_WAIT_CYC)) begin
              cnt    <= CntOne;
              ACTIVE <= SLAVE_EN;
              if (|SLAVE_EN) begin
                state <= StPdDrive;
                IO_PD <= 1'b1;
              end else begin
                state <= StIdle;
              end
            end
          end
          StPdDrive: begin
            if (cnt == CNT_W'(PD_LEN_CYC)) begin
              IO_PD <= 1'b0;
              state <= StCmdRx;
              idx   <= '0;
            end
          end
          StCmdRx: begin
            if (sample) begin
              wr_slot <= 1'b0;
              cmd_sr  <= {IO_IN, cmd_sr[6:1]};
              if (idx == 6'd7) begin
                CMD       <= cmd_byte;
                CMD_VALID <= 1'b1;
                idx       <= '0;
                sub       <= SubBit;
                case (cmd_byte)
                  8'h33:   state <= StRomTx;
                  8'h55:   state <= StMatch;
                  8'hF0:   state <= StSearch;
                  8'hCC:   state <= StDone;
                  default: begin
                    ACTIVE <= '0;
                    state  <= StDone;
                  end
                endcase
              end else begin
                idx <= idx + 6'd1;
              end
            end
          end
          StRomTx: begin
            if (fall) begin
              if (any0) begin
                IO_PD <= 1'b1;
                if (drv_cnt == '0 || drv_cnt == CNT_W'(DRIVE_CYC)) drv_cnt <= CntOne;
              end
              if (idx == 6'd63) state <= StDone;
              else              idx   <= idx + 6'd1;
            end
          end
          StMatch: begin
            if (sample) begin
              wr_slot <= 1'b0;
              ACTIVE  <= ACTIVE & keep;
              if (idx == 6'd63) state <= StDone;
              else              idx   <= idx + 6'd1;
            end
          end
          StSearch: begin
            case (sub)
              SubBit: begin
                if (fall) begin
                  if (any0) begin
                    IO_PD <= 1'b1;
                    if (drv_cnt == '0 || drv_cnt == CNT_W'(DRIVE_CYC)) drv_cnt <= CntOne;
                  end
                  sub <= SubCmp;
                end
              end
              SubCmp: begin
                if (fall) begin
                  if (any1) begin
                    IO_PD <= 1'b1;
                    if (drv_cnt == '0 || drv_cnt == CNT_W'(DRIVE_CYC)) drv_cnt <= CntOne;
                  end
                  sub <= SubDir;
                end
              end
              SubDir: begin
                if (sample) begin
                  wr_slot <= 1'b0;
                  ACTIVE  <= ACTIVE & keep;
                  sub     <= SubBit;
                  if (idx == 6'd63) state <= StDone;
                  else              idx   <= idx + 6'd1;
                end
              end
              default: sub <= SubBit;
            endcase
          end
          StDone: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ow_slave_array.sv
// Bus-master bench for ow_slave_array: a reference model predicts each response up front and a
// monitor pairs predictions with observations in order.
`timescale 1ns/1ps
module tb_ow_slave_array;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            mr;
  logic            m_low;
  logic            io_in;
  logic            io_pd;
  logic [64*N-1:0] romids;
  logic [N-1:0]    slave_en;
  logic [N-1:0]    active;
  logic [7:0]      cmd;
  logic            cmd_valid;
  logic            busy;
  logic [63:0]     rom [N];
  logic [N-1:0]    m_active;

  always #5 clk = ~clk;

  // Open-drain bus: low when either the master or any slave pulls down.
  assign io_in = !(m_low || io_pd);

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign romids[64*g +: 64] = rom[g];
  end

  ow_slave_array #(.NUM_SLAVES(N)) dut (
    .CLK(clk), .MR(mr), .IO_IN(io_in), .IO_PD(io_pd), .ROMIDS(romids), .SLAVE_EN(slave_en),
    .ACTIVE(active), .CMD(cmd), .CMD_VALID(cmd_valid), .BUSY(busy)
  );

  typedef struct {
    string       name;
    logic [63:0] v;
  } item_t;

  item_t      exp_q[$];
  item_t      act_q[$];
  logic [7:0] exp_cmd_q[$];
  int         errors = 0;
  int         checks = 0;

  always @(negedge clk) begin
    item_t      e;
    item_t      a;
    logic [7:0] ec;
    if (cmd_valid) begin
      checks++;
      if (exp_cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_valid: unexpected pulse with CMD=%h", cmd);
      end else begin
        ec = exp_cmd_q.pop_front();
        if (cmd !== ec) begin
          errors++;
          $display("FAIL cmd: got %h want %h", cmd, ec);
        end
      end
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a.v !== e.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, a.v, e.v);
      end
    end
  end

  task automatic push_exp(input string n, input logic [63:0] v);
    item_t it;
    it.name = n;
    it.v    = v;
    exp_q.push_back(it);
  endtask

  task automatic push_act(input string n, input logic [63:0] v);
    item_t it;
    it.name = n;
    it.v    = v;
    act_q.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    tick(b ? 5 : 40);
    m_low = 1'b0;
    tick(b ? 45 : 10);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    tick(3);
    m_low = 1'b0;
    tick(9);
    b = io_in;
    tick(38);
  endtask

  task automatic send_cmd(input logic [7:0] v);
    exp_cmd_q.push_back(v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  // Presence expected 30..149 cycles after the first high edge, only for a full-length reset.
  task automatic bus_reset(input int low_len, input string tag);
    logic pd;
    int   first;
    int   last;
    int   hi;
    pd = (low_len >= 480) && (slave_en != '0);
    if (low_len >= 480) m_active = slave_en;
    push_exp({tag, "_pd_first"}, pd ? 64'd30 : 64'd999);
    push_exp({tag, "_pd_last"}, pd ? 64'd149 : 64'd999);
    push_exp({tag, "_pd_len"}, pd ? 64'd120 : 64'd0);
    push_exp({tag, "_active"}, 64'(m_active));
    first = 999;
    last  = 999;
    hi    = 0;
    m_low = 1'b1;
    tick(low_len);
    m_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (io_pd) begin
        if (first == 999) first = k;
        last = k;
        hi++;
      end
    end
    push_act("", 64'(first));
    push_act("", 64'(last));
    push_act("", 64'(hi));
    push_act("", 64'(active));
  endtask

  task automatic read_rom(input string tag);
    logic [63:0] e;
    logic [63:0] o;
    logic        b;
    e = '1;
    for (int i = 0; i < N; i++) if (m_active[i]) e &= rom[i];
    push_exp({tag, "_id"}, e);
    push_exp({tag, "_active"}, 64'(m_active));
    send_cmd(8'h33);
    for (int k = 0; k < 64; k++) begin
      read_bit(b);
      o[k] = b;
    end
    push_act("", o);
    push_act("", 64'(active));
  endtask

  task automatic match_rom(input logic [63:0] target, input string tag);
    for (int i = 0; i < N; i++) if (rom[i] != target) m_active[i] = 1'b0;
    push_exp({tag, "_active"}, 64'(m_active));
    send_cmd(8'h55);
    for (int k = 0; k < 64; k++) write_bit(target[k]);
    push_act("", 64'(active));
  endtask

  // Reference search: per bit, bus reads AND of candidate bits and AND of their complements.
  task automatic search_rom(input int nbits, input logic rnd, input string tag);
    logic [N-1:0] cand;
    logic [63:0]  eb, ec, dirs, ob, oc;
    logic         any0, any1, b, c;
    cand = m_active;
    eb = '0; ec = '0; dirs = '0; ob = '0; oc = '0;
    for (int k = 0; k < nbits; k++) begin
      any0 = 1'b0;
      any1 = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          if (rom[i][k]) any1 = 1'b1;
          else           any0 = 1'b1;
        end
      end
      eb[k] = !any0;
      ec[k] = !any1;
      if (any0 && any1)  dirs[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      else if (any1)     dirs[k] = 1'b1;
      else if (any0)     dirs[k] = 1'b0;
      else               dirs[k] = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) if (cand[i] && rom[i][k] != dirs[k]) cand[i] = 1'b0;
    end
    push_exp({tag, "_bits"}, eb);
    push_exp({tag, "_cmps"}, ec);
    if (nbits == 64) push_exp({tag, "_active"}, 64'(cand));
    send_cmd(8'hF0);
    for (int k = 0; k < nbits; k++) begin
      read_bit(b);
      read_bit(c);
      ob[k] = b;
      oc[k] = c;
      write_bit(dirs[k]);
    end
    push_act("", ob);
    push_act("", oc);
    if (nbits == 64) begin
      push_act("", 64'(active));
      m_active = cand;
    end
  endtask

  task automatic rand_roms();
    for (int i = 0; i < N; i++) rom[i] = {$urandom(), $urandom()};
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       b;
    mr       = 1'b1;
    m_low    = 1'b0;
    slave_en = '0;
    m_active = '0;
    rand_roms();
    tick(3);
    mr = 1'b0;
    tick(1);
    push_exp("rst_io_pd", 64'd0);   push_act("", 64'(io_pd));
    push_exp("rst_active", 64'd0);  push_act("", 64'(active));
    push_exp("rst_cmd", 64'd0);     push_act("", 64'(cmd));
    push_exp("rst_busy", 64'd0);    push_act("", 64'(busy));

    // Short low pulse is not a reset; the full-length one is.
    slave_en = 4'b0101;
    bus_reset(479, "short_rst");
    push_exp("short_rst_busy", 64'd0); push_act("", 64'(busy));
    bus_reset(480, "rst0101");
    push_exp("rst0101_busy", 64'd1);   push_act("", 64'(busy));

    // Read ROM, single slave.
    rom[0]   = 64'h2800_000A_BC12_3401;
    slave_en = 4'b0001;
    bus_reset(480, "rd_rst");
    read_rom("read_rom");

    // Skip ROM keeps the selection; later slots are ignored.
    slave_en = 4'b0110;
    bus_reset(480, "skip_rst");
    send_cmd(8'hCC);
    push_exp("skip_active", 64'(m_active));
    for (int k = 0; k < 4; k++) begin
      read_bit(b);
      rd[k] = b;
    end
    push_act("", 64'(active));
    push_exp("skip_idle_bus", 64'hF); push_act("", 64'(rd[3:0]));

    // Search over four IDs differing only in the low byte, 0 chosen on conflict.
    for (int i = 0; i < N; i++) rom[i] = {56'h28_0000_0ABC_1234, 8'(i + 1)};
    slave_en = 4'b1111;
    bus_reset(480, "srch_rst");
    search_rom(64, 1'b0, "search_fixed");

    // Match ROM on slave 2.
    rand_roms();
    bus_reset(480, "match_rst");
    match_rom(rom[2], "match2");

    // Unknown command deselects everyone; no slave answers afterwards.
    bus_reset(480, "bad_rst");
    send_cmd(8'hA5);
    m_active = '0;
    push_exp("bad_active", 64'd0);
    for (int k = 0; k < 8; k++) begin
      read_bit(b);
      rd[k] = b;
    end
    push_act("", 64'(active));
    push_exp("bad_idle_bus", 64'hFF); push_act("", 64'(rd));

    // Bus reset in the middle of search bit 17.
    slave_en = 4'b1011;
    bus_reset(480, "abort_pre");
    search_rom(17, 1'b1, "search_part");
    bus_reset(480, "abort_rst");

    // Randomized rounds.
    rand_roms();
    slave_en = 4'($urandom_range(1, 15));
    bus_reset(480, "rnd_rst_a");
    search_rom(64, 1'b1, "search_rnd");
    rand_roms();
    slave_en = 4'($urandom_range(1, 15));
    bus_reset(480, "rnd_rst_b");
    match_rom(rom[$urandom_range(0, N - 1)], "match_rnd");

    // MR during the presence pulse releases the bus and clears everything.
    slave_en = 4'b1010;
    m_low    = 1'b1;
    tick(480);
    m_low = 1'b0;
    tick(60);
    push_exp("mr_pre_pd", 64'd1);    push_act("", 64'(io_pd));
    mr = 1'b1;
    tick(1);
    mr = 1'b0;
    push_exp("mr_io_pd", 64'd0);     push_act("", 64'(io_pd));
    push_exp("mr_active", 64'd0);    push_act("", 64'(active));
    push_exp("mr_busy", 64'd0);      push_act("", 64'(busy));
    push_exp("mr_cmd", 64'd0);       push_act("", 64'(cmd));
    tick(5);

    checks++;
    if (exp_q.size() != 0 || act_q.size() != 0 || exp_cmd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: leftover exp=%0d act=%0d cmd=%0d want 0 0 0",
               exp_q.size(), act_q.size(), exp_cmd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
